// File: rtl/hdmi_tx_init_sequencer.sv
// hdmi_tx_init_sequencer: walks the HDMI TX register table over a byte-level I2C write engine
module hdmi_tx_init_sequencer #(
  parameter int         TABLE_LEN        = 25,
  parameter logic [7:0] DEVICE_ADDR      = 8'h72,
  parameter int         POWERUP_CYCLES   = 10000000,
  parameter int         RETRY_GAP_CYCLES = 50000,
  parameter int         MAX_RETRIES      = 3
) (
  input  logic        clock_50,
  input  logic        reset_n,
  input  logic        interrupt,
  output logic [5:0]  table_index,
  input  logic [15:0] table_data,
  output logic        wr_start,
  output logic [7:0]  wr_dev,
  output logic [7:0]  wr_reg,
  output logic [7:0]  wr_val,
  input  logic        wr_busy,
  input  logic        wr_done,
  input  logic        wr_nack,
  output logic        config_done,
  output logic        config_error,
  output logic        busy
);
  localparam int DMAX = POWERUP_CYCLES > RETRY_GAP_CYCLES ? POWERUP_CYCLES : RETRY_GAP_CYCLES;
  localparam int CW = $clog2(DMAX + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  typedef enum logic [2:0] {POWER_WAIT, ISSUE, WAIT, GAP, DONE, FAIL} state_t;
  state_t state;
  logic [CW-1:0] delay_cnt;
  logic [RW-1:0] retry_cnt;
  logic [1:0] irq_sync;
  logic irq_prev, irq_pending, irq_evt, last;
  assign wr_dev = DEVICE_ADDR;
  assign irq_evt = irq_sync[1] & ~irq_prev;
  assign last = table_index == 6'(TABLE_LEN - 1);
  always_ff @(posedge clock_50 or negedge reset_n)
    if (!reset_n) begin
      state <= POWER_WAIT;
      delay_cnt <= '0;
      retry_cnt <= '0;
      irq_sync <= '0;
      irq_prev <= 1'b0;
      irq_pending <= 1'b0;
      table_index <= '0;
      wr_start <= 1'b0;
      wr_reg <= '0;
      wr_val <= '0;
      config_done <= 1'b0;
      config_error <= 1'b0;
      busy <= 1'b1;
    end else begin
      irq_sync <= {irq_sync[0], interrupt};
      irq_prev <= irq_sync[1];
      wr_start <= 1'b0;
      // later assignments in the case below take priority over this latch
      if (irq_evt && (state == ISSUE || state == WAIT || state == GAP)) irq_pending <= 1'b1;
      case (state)
        POWER_WAIT:
          if (delay_cnt == CW'(POWERUP_CYCLES - 1)) begin
            delay_cnt <= '0;
            table_index <= '0;
            state <= ISSUE;
          end else delay_cnt <= delay_cnt + 1'b1;
        ISSUE:
          if (!wr_busy) begin
            wr_reg <= table_data[15:8];
            wr_val <= table_data[7:0];
            wr_start <= 1'b1;
            state <= WAIT;
          end
        WAIT:
          if (wr_done) begin
            if (wr_nack) begin
              if (retry_cnt < RW'(MAX_RETRIES)) begin
                retry_cnt <= retry_cnt + 1'b1;
                delay_cnt <= '0;
                state <= GAP;
              end else begin
                config_error <= 1'b1;
                busy <= 1'b0;
                state <= FAIL;
              end
            end else if (irq_pending || irq_evt) begin
              irq_pending <= 1'b0;
              table_index <= '0;
              retry_cnt <= '0;
              state <= ISSUE;
            end else if (last) begin
              config_done <= 1'b1;
              busy <= 1'b0;
              state <= DONE;
            end else begin
              table_index <= table_index + 1'b1;
              retry_cnt <= '0;
              state <= ISSUE;
            end
          end
        GAP:
          if (delay_cnt == CW'(RETRY_GAP_CYCLES - 1)) begin
            delay_cnt <= '0;
            state <= ISSUE;
          end else delay_cnt <= delay_cnt + 1'b1;
        DONE, FAIL:
          if (irq_evt) begin
            config_done <= 1'b0;
            config_error <= 1'b0;
            busy <= 1'b1;
            table_index <= '0;
            retry_cnt <= '0;
            irq_pending <= 1'b0;
            state <= ISSUE;
          end
        default: state <= POWER_WAIT;
      endcase
    end
endmodule

// File: tb/tb_hdmi_tx_init_sequencer.sv
// tb_hdmi_tx_init_sequencer: table-driven NACK scenarios plus interrupt and reset sequences
module tb_hdmi_tx_init_sequencer;
  localparam int TL = 25;
  localparam int PU = 100;
  localparam int RG = 30;
  localparam int MR = 3;
  localparam int ENG_LAT = 20;
  logic clock_50, reset_n, interrupt;
  logic [5:0] table_index;
  logic [15:0] table_data;
  logic wr_start, wr_busy, wr_done, wr_nack, config_done, config_error, busy;
  logic [7:0] wr_dev, wr_reg, wr_val;
  int passed = 0, total = 0;
  int cyc, eng_cnt, nack_entry, nack_left, idx_viol, hold_viol, dup_start;
  logic [7:0] cur_reg, cur_val;
  logic [7:0] log_reg[$], log_val[$];
  int log_cyc[$], exp_q[$];
  typedef struct {
    int nack_entry;
    int nack_cnt;
    int exp_writes;
    bit exp_done;
    bit exp_err;
  } vec_t;
  vec_t vecs[5];

  hdmi_tx_init_sequencer #(
    .TABLE_LEN(TL), .DEVICE_ADDR(8'h72), .POWERUP_CYCLES(PU),
    .RETRY_GAP_CYCLES(RG), .MAX_RETRIES(MR)
  ) dut (
    .clock_50(clock_50), .reset_n(reset_n), .interrupt(interrupt),
    .table_index(table_index), .table_data(table_data), .wr_start(wr_start),
    .wr_dev(wr_dev), .wr_reg(wr_reg), .wr_val(wr_val), .wr_busy(wr_busy),
    .wr_done(wr_done), .wr_nack(wr_nack), .config_done(config_done),
    .config_error(config_error), .busy(busy)
  );

  // register table: entry i writes reg i+1 with value 3*i
  assign table_data = {8'(table_index + 6'd1), 8'(table_index * 6'd3)};

  initial begin
    clock_50 = 0;
    forever #5 clock_50 = ~clock_50;
  end

  // I2C engine model: wr_done ENG_LAT cycles after wr_start, optional NACKs
  initial begin
    wr_busy = 0; wr_done = 0; wr_nack = 0; eng_cnt = 0; cyc = 0;
    idx_viol = 0; hold_viol = 0; dup_start = 0;
    forever begin
      @(posedge clock_50); #1;
      if (!reset_n) begin
        wr_busy = 0; wr_done = 0; wr_nack = 0; eng_cnt = 0; cyc = 0;
      end else begin
        cyc++;
        wr_done = 0; wr_nack = 0;
        if (table_index > 6'(TL - 1)) idx_viol++;
        if (eng_cnt > 0) begin
          if (wr_start) dup_start++;
          if (wr_reg != cur_reg || wr_val != cur_val) hold_viol++;
          eng_cnt--;
          if (eng_cnt == 0) begin
            wr_busy = 0; wr_done = 1;
            if (int'(cur_reg) - 1 == nack_entry && nack_left > 0) begin
              wr_nack = 1; nack_left--;
            end
          end
        end else if (wr_start) begin
          log_reg.push_back(wr_reg); log_val.push_back(wr_val); log_cyc.push_back(cyc);
          cur_reg = wr_reg; cur_val = wr_val; wr_busy = 1; eng_cnt = ENG_LAT;
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_log();
    log_reg.delete(); log_val.delete(); log_cyc.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clock_50); reset_n = 0;
    repeat (3) @(negedge clock_50);
    clear_log();
    reset_n = 1;
  endtask

  task automatic exp_range(input int a, input int b);
    for (int i = a; i <= b; i++) exp_q.push_back(i);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock_50);
      if (!busy) break;
    end
    chk({name, "_reach_idle"}, busy, 0);
  endtask

  task automatic wait_log(input string name, input int n);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock_50);
      if (log_reg.size() >= n) break;
    end
    chk({name, "_reach_write"}, log_reg.size() >= n, 1);
  endtask

  task automatic check_order(input string name);
    int mism = 0;
    chk({name, "_writes"}, log_reg.size(), exp_q.size());
    for (int i = 0; i < log_reg.size() && i < exp_q.size(); i++)
      if (log_reg[i] != 8'(exp_q[i] + 1) || log_val[i] != 8'(exp_q[i] * 3)) mism++;
    chk({name, "_order"}, mism, 0);
  endtask

  task automatic pulse_irq(input int width);
    @(negedge clock_50); interrupt = 1;
    repeat (width) @(negedge clock_50);
    interrupt = 0;
  endtask

  initial begin
    int irq_cyc, ec, att;
    vecs[0] = '{-1, 0, 25, 1'b1, 1'b0};
    vecs[1] = '{5, 1, 26, 1'b1, 1'b0};
    vecs[2] = '{7, 100, 11, 1'b0, 1'b1};
    vecs[3] = '{0, 3, 28, 1'b1, 1'b0};
    vecs[4] = '{24, 4, 28, 1'b0, 1'b1};
    reset_n = 0; interrupt = 0; nack_entry = -1; nack_left = 0;
    repeat (2) @(negedge clock_50);
    chk("rst_table_index", table_index, 0);
    chk("rst_wr_start", wr_start, 0);
    chk("rst_wr_reg", wr_reg, 0);
    chk("rst_wr_val", wr_val, 0);
    chk("rst_config_done", config_done, 0);
    chk("rst_config_error", config_error, 0);
    chk("rst_busy", busy, 1);
    chk("wr_dev", wr_dev, 8'h72);

    foreach (vecs[v]) begin
      nack_entry = vecs[v].nack_entry; nack_left = vecs[v].nack_cnt;
      do_reset();
      for (int e = 0; e < TL; e++) begin
        att = (e == nack_entry) ? ((nack_left > MR) ? MR + 1 : nack_left + 1) : 1;
        for (int a = 0; a < att; a++) exp_q.push_back(e);
        if (e == nack_entry && nack_left > MR) break;
      end
      wait_idle($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_writes_tbl", v), log_reg.size(), vecs[v].exp_writes);
      check_order($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_done", v), config_done, vecs[v].exp_done);
      chk($sformatf("vec%0d_error", v), config_error, vecs[v].exp_err);
      if (v == 0) begin
        chk("first_start_cycle", log_cyc.size() > 0 ? log_cyc[0] : -1, PU + 1);
        chk("first_reg", log_reg.size() > 0 ? log_reg[0] : 8'hff, 8'h01);
        chk("first_val", log_val.size() > 0 ? log_val[0] : 8'hff, 8'h00);
      end
      if (nack_entry >= 0 && log_cyc.size() > nack_entry + 1)
        chk($sformatf("vec%0d_retry_gap", v),
            log_cyc[nack_entry + 1] - log_cyc[nack_entry] >= ENG_LAT + RG, 1);
    end

    // interrupt out of FAIL: entry 24 now acks, so the rerun completes
    clear_log(); nack_left = 0; exp_range(0, TL - 1);
    pulse_irq(3);
    wait_idle("fail_irq");
    check_order("fail_irq");
    chk("fail_irq_error", config_error, 0);
    chk("fail_irq_done", config_done, 1);

    // 3-cycle interrupt in DONE: rerun without power-up wait
    clear_log(); exp_range(0, TL - 1);
    irq_cyc = cyc + 1;
    pulse_irq(3);
    repeat (3) @(negedge clock_50);
    chk("done_irq_done_low", config_done, 0);
    wait_idle("done_irq");
    check_order("done_irq");
    chk("done_irq_no_powerup", log_cyc.size() > 0 && log_cyc[0] - irq_cyc <= 6, 1);
    chk("done_irq_done", config_done, 1);

    // interrupt during entry 10's write
    nack_entry = -1; do_reset();
    exp_range(0, 10); exp_range(0, TL - 1);
    wait_log("wait_irq", 11);
    pulse_irq(3);
    wait_idle("wait_irq");
    check_order("wait_irq");
    chk("wait_irq_done", config_done, 1);

    // interrupt edge lands exactly on the last entry's wr_done
    do_reset();
    exp_range(0, TL - 1); exp_range(0, TL - 1);
    wait_log("last_irq", TL);
    ec = log_cyc.size() >= TL ? log_cyc[TL - 1] : 0;
    for (int k = 0; k < 40 && cyc < ec + ENG_LAT - 2; k++) @(negedge clock_50);
    chk("last_irq_align", cyc, ec + ENG_LAT - 2);
    interrupt = 1;
    repeat (3) @(negedge clock_50);
    interrupt = 0;
    wait_idle("last_irq");
    check_order("last_irq");
    chk("last_irq_done", config_done, 1);

    // reset pulse during entry 12's write
    do_reset();
    wait_log("mid_rst", 13);
    repeat (5) @(negedge clock_50);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_index", table_index, 0);
    chk("mid_rst_wr_reg", wr_reg, 0);
    chk("mid_rst_wr_val", wr_val, 0);
    chk("mid_rst_wr_start", wr_start, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_done", config_done, 0);
    repeat (2) @(negedge clock_50);
    clear_log(); exp_range(0, TL - 1);
    reset_n = 1;
    wait_idle("mid_rst");
    check_order("mid_rst");
    chk("mid_rst_first_cycle", log_cyc.size() > 0 ? log_cyc[0] : -1, PU + 1);
    chk("mid_rst_done_end", config_done, 1);

    chk("index_in_range", idx_viol, 0);
    chk("operands_held", hold_viol, 0);
    chk("single_cycle_start", dup_start, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hdmi_tx_init_sequencer.md
Name: hdmi_tx_init_sequencer

Overview:
- Sequences the HDMI transmitter register-configuration table over a byte-level I2C write engine.
- Waits a power-up delay, then walks table entries 0..TABLE_LEN-1 and issues one 3-byte write (device, register, value) per entry.
- Retries NACKed writes and re-runs the whole table on a hot-plug interrupt.
- Sits between the register lookup table and the I2C master.

Parameters:
- TABLE_LEN, 25: number of table entries written per pass (1..64).
- DEVICE_ADDR, 8'h72: 8-bit I2C write address of the transmitter.
- POWERUP_CYCLES, 10000000: clock_50 cycles to wait after reset before the first write (200 ms).
- RETRY_GAP_CYCLES, 50000: idle cycles between a NACK and the retry of the same entry (1 ms).
- MAX_RETRIES, 3: retries per entry after the first attempt.

Ports:
- clock_50  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- interrupt  in  1  transmitter interrupt/HPD, asynchronous, active-high.
- table_index  out  6  table entry address.
- table_data  in  16  {reg_addr[15:8], value[7:0]}; combinationally valid in the same cycle for table_index.
- wr_start  out  1  one-cycle pulse that starts an I2C write.
- wr_dev  out  8  device address, constant DEVICE_ADDR.
- wr_reg  out  8  register address, held stable from wr_start to wr_done.
- wr_val  out  8  register value, held stable from wr_start to wr_done.
- wr_busy  in  1  I2C engine busy.
- wr_done  in  1  one-cycle pulse when a write completes.
- wr_nack  in  1  valid only with wr_done; 1 means a slave NACK.
- config_done  out  1  level; a full pass completed without failure.
- config_error  out  1  level; an entry exhausted its retries.
- busy  out  1  high in every state except DONE and FAIL.

Behaviour:
- Reset values: table_index=0, wr_start=0, wr_reg=0, wr_val=0, config_done=0, config_error=0, busy=1, FSM=POWER_WAIT, delay counter=0, retry counter=0, irq_pending=0.
- interrupt passes through a 2-flop synchroniser; a rising edge on the synchronised signal produces irq_evt.
- POWER_WAIT: count up to POWERUP_CYCLES-1, then go to ISSUE with table_index=0.
- ISSUE: when wr_busy=0:
  - latch wr_reg=table_data[15:8] and wr_val=table_data[7:0];
  - pulse wr_start for exactly one cycle;
  - go to WAIT.
  - If wr_busy=1, hold in ISSUE with no pulse.
- WAIT: wait for wr_done.
  - wr_nack=0:
    - if irq_pending=1: clear it, set table_index=0, clear retry count, go to ISSUE;
    - else if table_index==TABLE_LEN-1: go to DONE;
    - else: increment table_index, clear retry count, go to ISSUE.
  - wr_nack=1:
    - if retry count < MAX_RETRIES: increment it, go to GAP;
    - else: go to FAIL.
- GAP: count RETRY_GAP_CYCLES, then return to ISSUE with the same index.
- DONE: config_done=1, busy=0. On irq_evt: clear config_done, set table_index=0, go to ISSUE (no power-up wait).
- FAIL: config_error=1, busy=0. On irq_evt: clear config_error, restart from index 0 in ISSUE.
- irq_evt in POWER_WAIT, ISSUE or GAP: ignored in POWER_WAIT; in ISSUE/GAP sets irq_pending.
- irq_evt in WAIT: sets irq_pending. An in-flight write is never aborted.
- irq_evt coincident with the wr_done of the last entry: pending wins; restart instead of DONE.
- Latency: one cycle from entering ISSUE (with wr_busy=0) to wr_start. A pass with no NACKs and an idle engine takes TABLE_LEN writes plus 2 cycles of overhead per entry.
- wr_done while not in WAIT is ignored.
- Reset assertion mid-write: immediate return to reset values. The engine is expected to be reset by the same reset_n.
- table_index never exceeds TABLE_LEN-1.

Test Plan:
- Engine model: wr_done 20 cycles after wr_start, never NACKs; POWERUP_CYCLES=100 -> first wr_start at cycle 101 after reset release. The first write carries wr_dev=72, wr_reg=01, wr_val=00. Exactly 25 writes occur in index order, then config_done=1 and busy=0.
- NACK on the first attempt of entry 5 only -> entry 5 is written twice, the gap between attempts is ≥RETRY_GAP_CYCLES, the sequence completes, config_error=0.
- NACK every attempt of entry 7 with MAX_RETRIES=3 -> 4 attempts, then config_error=1, config_done=0, no write to entry 8.
- Interrupt pulse 3 cycles wide in DONE -> config_done falls, 25 new writes start at index 0 with no power-up delay, then config_done=1.
- Interrupt asserted during entry 10's WAIT -> entry 10 completes, the next write is entry 0, and the full 25-entry pass follows. Repeat with the interrupt on the last entry's wr_done cycle -> restart, no DONE.
- reset_n low for 2 cycles during entry 12 -> all outputs return to reset values asynchronously; after release, the power-up wait reruns and the sequence restarts at entry 0.
